vga_timing_ctrl: RTL

//  Raster timing master for the VGA display path; the driving end of the pixel-coordinate interface.

---
 rtl/vga_timing_pkg.sv | 46 ++++
 rtl/vga_timing_ctrl_axis.sv | 54 +++++
 rtl/vga_timing_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing_pkg                                               |
// | Description : Shared widths, default 640x480@60 timing, phase encoding and |
// |               the record carried down the HS/VS/BLANK_n alignment line.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Sum of the four phases of one axis
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Phase of one raster axis, decoded from its counter
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_e;

  // Timing flags that travel alongside the renderer latency
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } align_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_ctrl_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_axis_counter                                             |
// | Description : One raster axis: wrapping counter over ACTIVE+FP+SYNC+BP     |
// |               with a combinational phase decode and wrap strobe.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output phase_e             phase
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] FP_START   = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE + FP);
  localparam logic [COORD_W-1:0] BP_START   = COORD_W'(ACTIVE + FP + SYNC);

  assign wrap = enable && (count == LAST);

  // Advance when enabled, returning to zero after the last back-porch position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + COORD_W'(1);
    end
  end

  // Phase is a pure decode of the count: no separate state register
  always_comb begin
    phase = PH_ACTIVE;
    if (count >= BP_START) begin
      phase = PH_BP;
    end else if (count >= SYNC_START) begin
      phase = PH_SYNC;
    end else if (count >= FP_START) begin
      phase = PH_FP;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing_ctrl                                              |
// | Description : VGA raster timing master. Issues pixel coordinates to the    |
// |               renderer and re-aligns its RGB with HS/VS/BLANK_n.           |
// |               Optional: VGA_BORDER_EN draws a 1-pixel white frame.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIX_LAT  = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               iVGA_CLK,
  input  logic               iRST,
  output logic [COORD_W-1:0] oVGA_X,
  output logic [COORD_W-1:0] oVGA_Y,
  output logic               oREQ,
  output logic               oFRAME_START,
  input  logic [RGB_W-1:0]   iRed,
  input  logic [RGB_W-1:0]   iGreen,
  input  logic [RGB_W-1:0]   iBlue,
  output logic [RGB_W-1:0]   oVGA_R,
  output logic [RGB_W-1:0]   oVGA_G,
  output logic [RGB_W-1:0]   oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK_n,
  output logic               oVGA_SYNC_n
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam align_t ALIGN_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, blank_n: 1'b0};

  generate
    if (H_TOTAL > (1 << COORD_W)) begin : g_h_total_chk
      $error("vga_timing_ctrl: H_TOTAL exceeds the 10-bit counter range");
    end
    if (V_TOTAL > (1 << COORD_W)) begin : g_v_total_chk
      $error("vga_timing_ctrl: V_TOTAL exceeds the 10-bit counter range");
    end
    if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_pix_lat_chk
      $error("vga_timing_ctrl: PIX_LAT must be within 1..4");
    end
  endgenerate

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_wrap;
  logic               v_wrap;
  phase_e             h_phase;
  phase_e             v_phase;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk    (iVGA_CLK),
    .rst    (iRST),
    .enable (1'b1),
    .count  (h_cnt),
    .wrap   (h_wrap),
    .phase  (h_phase)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk    (iVGA_CLK),
    .rst    (iRST),
    .enable (h_wrap),
    .count  (v_cnt),
    .wrap   (v_wrap),
    .phase  (v_phase)
  );

  // Combinational outputs are held quiet while reset is asserted
  logic live;
  logic visible;
  logic frame_q;

  assign live    = ~iRST;
  assign visible = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

  assign oREQ         = visible && live;
  assign oVGA_X       = oREQ ? h_cnt : '0;
  assign oVGA_Y       = oREQ ? v_cnt : '0;
  assign oFRAME_START = frame_q && live;
  assign oVGA_SYNC_n  = 1'b1;

  // Marks the cycle at h=0,v=0: set by reset (restart) and by the frame wrap
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      frame_q <= 1'b1;
    end else begin
      frame_q <= v_wrap;
    end
  end

  align_t align_raw;
  align_t align_dly [PIX_LAT];
  align_t align_out;

  assign align_raw = '{hs:      (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL,
                       vs:      (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL,
                       blank_n: visible};
  assign align_out = align_dly[PIX_LAT-1];

  // Delay the timing flags by the renderer latency so they meet its RGB
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < PIX_LAT; i++) begin
        align_dly[i] <= ALIGN_IDLE;
      end
    end else begin
      align_dly[0] <= align_raw;
      for (int i = 1; i < PIX_LAT; i++) begin
        align_dly[i] <= align_dly[i-1];
      end
    end
  end

  logic [RGB_W-1:0] pix_r;
  logic [RGB_W-1:0] pix_g;
  logic [RGB_W-1:0] pix_b;

`ifdef VGA_BORDER_EN
  logic border_raw;
  logic border_dly [PIX_LAT];

  assign border_raw = visible && ((h_cnt == '0) || (h_cnt == COORD_W'(H_ACTIVE - 1)) ||
                                  (v_cnt == '0) || (v_cnt == COORD_W'(V_ACTIVE - 1)));

  // Border flag rides the same delay as BLANK_n
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < PIX_LAT; i++) begin
        border_dly[i] <= 1'b0;
      end
    end else begin
      border_dly[0] <= border_raw;
      for (int i = 1; i < PIX_LAT; i++) begin
        border_dly[i] <= border_dly[i-1];
      end
    end
  end

  assign pix_r = border_dly[PIX_LAT-1] ? {RGB_W{1'b1}} : iRed;
  assign pix_g = border_dly[PIX_LAT-1] ? {RGB_W{1'b1}} : iGreen;
  assign pix_b = border_dly[PIX_LAT-1] ? {RGB_W{1'b1}} : iBlue;
`else
  assign pix_r = iRed;
  assign pix_g = iGreen;
  assign pix_b = iBlue;
`endif

  // Output register: syncs, blank and blank-gated RGB leave together
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      oVGA_HS      <= ~SYNC_POL;
      oVGA_VS      <= ~SYNC_POL;
      oVGA_BLANK_n <= 1'b0;
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
    end else begin
      oVGA_HS      <= align_out.hs;
      oVGA_VS      <= align_out.vs;
      oVGA_BLANK_n <= align_out.blank_n;
      oVGA_R       <= align_out.blank_n ? pix_r : '0;
      oVGA_G       <= align_out.blank_n ? pix_g : '0;
      oVGA_B       <= align_out.blank_n ? pix_b : '0;
    end
  end

endmodule
`default_nettype wire
